// File: rtl/clock_mode_pkg.sv
// Shared encodings for the clock user-interface sequencer: states, edit
// field indices, per-field digit maxima and buzzer ring sources.
package clock_mode_pkg;

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    SET_CLK   = 3'd1,
    SET_ALM   = 3'd2,
    SET_TMR   = 3'd3,
    STOPWATCH = 3'd4,
    TIMER_RUN = 3'd5
  } state_t;

  localparam logic [2:0] F_S2 = 3'd0;
  localparam logic [2:0] F_S1 = 3'd1;
  localparam logic [2:0] F_M2 = 3'd2;
  localparam logic [2:0] F_M1 = 3'd3;
  localparam logic [2:0] F_H2 = 3'd4;
  localparam logic [2:0] F_H1 = 3'd5;

  localparam logic [3:0] MAX_UNITS    = 4'd9;  // s2, m2, h2 (h1 < 2)
  localparam logic [3:0] MAX_TENS     = 4'd5;  // s1, m1
  localparam logic [3:0] MAX_H2_AT_20 = 4'd3;  // h2 once h1 == 2
  localparam logic [3:0] MAX_H1       = 4'd2;

  typedef enum logic [1:0] {
    RING_NONE = 2'b00,
    RING_ALM  = 2'b01,
    RING_TMR  = 2'b10
  } ring_t;

  function automatic logic [3:0] field_max(input logic [2:0] sel, input logic [3:0] h1);
    case (sel)
      F_S1, F_M1: field_max = MAX_TENS;
      F_H2:       field_max = (h1 == 4'd2) ? MAX_H2_AT_20 : MAX_UNITS;
      F_H1:       field_max = MAX_H1;
      default:    field_max = MAX_UNITS;
    endcase
  endfunction

  function automatic logic is_edit(input state_t s);
    is_edit = (s == SET_CLK) || (s == SET_ALM) || (s == SET_TMR);
  endfunction

  // The alarm has no seconds, so its edit ends on the minutes-units field.
  function automatic logic [2:0] last_field(input state_t s);
    last_field = (s == SET_ALM) ? F_M2 : F_S2;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_edge.sv
// Rising-edge detector for one push-button level. History resets high so a
// button held through reset does not register a press.
module btn_edge (
  input  logic clk_out,
  input  logic swrst,
  input  logic level,
  output logic rise
);

  logic hist;

  // NOTE: sequential state uses non-blocking assignments and the async reset
  // sits in the sensitivity list, so reset acts without waiting for a tick.
  always_ff @(posedge clk_out or posedge swrst) begin
    if (swrst) hist <= 1'b1;
    else       hist <= level;
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode/edit sequencer for the digital clock, plus the
// alarm/timer buzzer arbiter with acknowledge and auto-stop.
module clock_mode_ctrl
  import clock_mode_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 30,
  parameter int BUZZ_MAX     = 60,
  parameter int CW           = 6
) (
  input  logic       clk_out,
  input  logic       swrst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       alm_hit,
  input  logic       tmr_zero,
  output logic       load,
  output logic       almin,
  output logic       tmrin,
  output logic       sw,
  output logic       tmr,
  output logic [2:0] select,
  output logic [3:0] loadin,
  output logic       buzz_out,
  output logic [1:0] ring_src,
  output logic [2:0] mode
);

  state_t        state, state_nx;
  ring_t         ring, ring_nx;
  logic [2:0]    select_nx;
  logic [3:0]    loadin_nx, h1, h1_nx;
  logic [CW-1:0] idle_cnt, idle_nx, ring_cnt, ring_cnt_nx;
  logic          rise_mode, rise_next, rise_inc, any_edge;
  logic          ev_mode, ev_next, ev_inc;
  logic          alm_hist, tz_hist, tz_cond, alm_rise, tz_rise;

  btn_edge u_edge_mode (.clk_out(clk_out), .swrst(swrst), .level(btn_mode), .rise(rise_mode));
  btn_edge u_edge_next (.clk_out(clk_out), .swrst(swrst), .level(btn_next), .rise(rise_next));
  btn_edge u_edge_inc  (.clk_out(clk_out), .swrst(swrst), .level(btn_inc),  .rise(rise_inc));

  assign any_edge = rise_mode | rise_next | rise_inc;
  assign tz_cond  = tmr_zero & tmr;
  assign tz_rise  = tz_cond & ~tz_hist;
  assign alm_rise = alm_hit & ~alm_hist;

  // NOTE: every variable gets its hold value first, so no path through the
  // branches below can leave one unassigned and infer a latch.
  always_comb begin
    state_nx    = state;
    select_nx   = select;
    loadin_nx   = loadin;
    h1_nx       = h1;
    idle_nx     = idle_cnt;
    ring_nx     = ring;
    ring_cnt_nx = ring_cnt;
    ev_mode     = rise_mode;
    ev_next     = rise_next & ~rise_mode;
    ev_inc      = rise_inc & ~rise_mode & ~rise_next;

    if (ring != RING_NONE) begin
      if (any_edge) begin
        // The acknowledging press is swallowed by the buzzer.
        ring_nx     = RING_NONE;
        ring_cnt_nx = '0;
        ev_mode     = 1'b0;
        ev_next     = 1'b0;
        ev_inc      = 1'b0;
        if (ring == RING_TMR && state == TIMER_RUN) state_nx = CLOCK;
      end else if (ring_cnt == CW'(BUZZ_MAX - 1)) begin
        ring_nx     = RING_NONE;
        ring_cnt_nx = '0;
      end else begin
        ring_cnt_nx = ring_cnt + 1'b1;
      end
    end else if (tz_rise) begin
      ring_nx     = RING_TMR;
      ring_cnt_nx = '0;
    end else if (alm_rise) begin
      ring_nx     = RING_ALM;
      ring_cnt_nx = '0;
    end

    if (ev_mode) begin
      case (state)
        CLOCK:   state_nx = SET_CLK;
        SET_CLK: state_nx = SET_ALM;
        SET_ALM: state_nx = SET_TMR;
        SET_TMR: state_nx = STOPWATCH;
        default: state_nx = CLOCK;
      endcase
      select_nx = is_edit(state_nx) ? F_H1 : F_S2;
      loadin_nx = 4'd0;
      idle_nx   = '0;
    end else if (is_edit(state)) begin
      if (any_edge) idle_nx = '0;
      if (ev_next) begin
        if (select == last_field(state)) begin
          state_nx  = (state == SET_TMR) ? TIMER_RUN : CLOCK;
          select_nx = F_S2;
        end else begin
          if (select == F_H1) h1_nx = loadin;
          select_nx = select - 3'd1;
        end
        loadin_nx = 4'd0;
      end else if (ev_inc) begin
        loadin_nx = (loadin == field_max(select, h1)) ? 4'd0 : loadin + 4'd1;
      end else if (!any_edge) begin
        if (idle_cnt == CW'(IDLE_TIMEOUT - 1)) begin
          state_nx  = CLOCK;
          select_nx = F_S2;
          loadin_nx = 4'd0;
          idle_nx   = '0;
        end else begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
    end else begin
      idle_nx = '0;
    end
  end

  always_ff @(posedge clk_out or posedge swrst) begin
    if (swrst) begin
      state    <= CLOCK;
      select   <= F_S2;
      loadin   <= 4'd0;
      h1       <= 4'd0;
      idle_cnt <= '0;
      ring     <= RING_NONE;
      ring_cnt <= '0;
      buzz_out <= 1'b0;
      load     <= 1'b0;
      almin    <= 1'b0;
      tmrin    <= 1'b0;
      sw       <= 1'b0;
      tmr      <= 1'b0;
      alm_hist <= 1'b0;
      tz_hist  <= 1'b0;
    end else begin
      state    <= state_nx;
      select   <= select_nx;
      loadin   <= loadin_nx;
      h1       <= h1_nx;
      idle_cnt <= idle_nx;
      ring     <= ring_nx;
      ring_cnt <= ring_cnt_nx;
      buzz_out <= (ring_nx != RING_NONE);
      load     <= (state_nx == SET_CLK);
      almin    <= (state_nx == SET_ALM);
      tmrin    <= (state_nx == SET_TMR);
      sw       <= (state_nx == STOPWATCH);
      tmr      <= (state_nx == TIMER_RUN);
      alm_hist <= alm_hit;
      tz_hist  <= tz_cond;
    end
  end

  assign ring_src = ring;
  assign mode     = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: a tick-level behavioural model is
// compared every cycle, with literal expectations at key points of each scenario.
module tb_clock_mode_ctrl;

  localparam int IDLE_TIMEOUT = 30;
  localparam int BUZZ_MAX     = 60;

  logic       clk_out = 1'b0;
  logic       swrst   = 1'b1;
  logic       btn_mode = 1'b1, btn_next = 1'b0, btn_inc = 1'b0;
  logic       alm_hit = 1'b0, tmr_zero = 1'b0;
  logic       load, almin, tmrin, sw, tmr, buzz_out;
  logic [2:0] select, mode;
  logic [3:0] loadin;
  logic [1:0] ring_src;

  int checks   = 0;
  int failures = 0;

  clock_mode_ctrl dut (
    .clk_out(clk_out), .swrst(swrst),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .alm_hit(alm_hit), .tmr_zero(tmr_zero),
    .load(load), .almin(almin), .tmrin(tmrin), .sw(sw), .tmr(tmr),
    .select(select), .loadin(loadin),
    .buzz_out(buzz_out), .ring_src(ring_src), .mode(mode)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: states 0..5 as in the mode encoding, ring 0/1/2.
  int m_state, m_sel, m_dig, m_h1, m_idle, m_ring, m_rung;
  bit pm, pn, pi, pa, pz;
  int next_mode[6] = '{1, 2, 3, 4, 0, 0};
  int digit_max[6] = '{9, 5, 9, 5, 9, 2};

  always @(posedge clk_out or posedge swrst) begin
    if (swrst) begin
      m_state = 0; m_sel = 0; m_dig = 0; m_h1 = 0; m_idle = 0; m_ring = 0; m_rung = 0;
      pm = 1; pn = 1; pi = 1; pa = 0; pz = 0;
    end else begin
      bit em, en, ei, ea, ez, edge_any, edit_now;
      int action, limit;
      em = btn_mode && !pm;
      en = btn_next && !pn;
      ei = btn_inc && !pi;
      ea = alm_hit && !pa;
      ez = (tmr_zero && m_state == 5) && !pz;
      pm = btn_mode; pn = btn_next; pi = btn_inc; pa = alm_hit;
      pz = tmr_zero && m_state == 5;
      edge_any = em || en || ei;
      action = em ? 1 : (en ? 2 : (ei ? 3 : 0));

      if (m_ring != 0) begin
        if (edge_any) begin
          if (m_ring == 2 && m_state == 5) m_state = 0;
          m_ring = 0;
          action = 0;
        end else begin
          m_rung++;
          if (m_rung == BUZZ_MAX) m_ring = 0;
        end
      end else if (ez) begin
        m_ring = 2; m_rung = 0;
      end else if (ea) begin
        m_ring = 1; m_rung = 0;
      end

      edit_now = (m_state >= 1 && m_state <= 3);
      if (action == 1) begin
        m_state = next_mode[m_state];
        m_sel = (m_state >= 1 && m_state <= 3) ? 5 : 0;
        m_dig = 0;
        m_idle = 0;
      end else if (edit_now) begin
        if (edge_any) m_idle = 0;
        if (action == 2) begin
          if (m_sel == ((m_state == 2) ? 2 : 0)) begin
            m_state = (m_state == 3) ? 5 : 0;
            m_sel = 0;
          end else begin
            if (m_sel == 5) m_h1 = m_dig;
            m_sel--;
          end
          m_dig = 0;
        end else if (action == 3) begin
          limit = (m_sel == 4 && m_h1 == 2) ? 3 : digit_max[m_sel];
          m_dig = (m_dig + 1) % (limit + 1);
        end else if (!edge_any) begin
          m_idle++;
          if (m_idle == IDLE_TIMEOUT) begin
            m_state = 0; m_sel = 0; m_dig = 0; m_idle = 0;
          end
        end
      end else begin
        m_idle = 0;
      end
    end
  end

  always @(negedge clk_out) begin
    if (!swrst) begin
      check("cmp_mode",   mode,     m_state);
      check("cmp_load",   load,     int'(m_state == 1));
      check("cmp_almin",  almin,    int'(m_state == 2));
      check("cmp_tmrin",  tmrin,    int'(m_state == 3));
      check("cmp_sw",     sw,       int'(m_state == 4));
      check("cmp_tmr",    tmr,      int'(m_state == 5));
      check("cmp_select", select,   m_sel);
      check("cmp_loadin", loadin,   m_dig);
      check("cmp_buzz",   buzz_out, int'(m_ring != 0));
      check("cmp_ring",   ring_src, m_ring);
    end
  end

  // One tick: drive inputs just after a rising edge, then wait for the next.
  task automatic cyc(input logic m, input logic n, input logic i, input logic a, input logic z);
    btn_mode = m; btn_next = n; btn_inc = i; alm_hit = a; tmr_zero = z;
    @(posedge clk_out);
    #1;
  endtask

  task automatic press(input int which);
    cyc(which == 0, which == 1, which == 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam int B_MODE = 0, B_NEXT = 1, B_INC = 2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with mode held high, then keep holding: no edge.
    repeat (2) @(posedge clk_out);
    #1 swrst = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_mode_state", mode, 0);
    check("held_mode_load", load, 0);
    check("held_mode_select", select, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Set clock: h1=2 so h2 wraps at 3.
    press(B_MODE);
    check("setclk_mode", mode, 1);
    check("setclk_load", load, 1);
    check("setclk_select", select, 5);
    repeat (2) press(B_INC);
    check("h1_two", loadin, 2);
    press(B_NEXT);
    check("h2_select", select, 4);
    repeat (4) press(B_INC);
    check("h2_wrap", loadin, 0);
    press(B_NEXT);
    repeat (5) press(B_NEXT);
    check("setclk_commit_mode", mode, 0);
    check("setclk_commit_load", load, 0);

    // Idle timeout in SET_TMR.
    press(B_MODE); press(B_MODE);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (IDLE_TIMEOUT - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_tick29_tmrin", tmrin, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_tick30_tmrin", tmrin, 0);
    check("timeout_mode", mode, 0);
    check("timeout_select", select, 0);

    // Timer commit, ring, acknowledge.
    repeat (3) press(B_MODE);
    repeat (6) press(B_NEXT);
    check("timer_run_mode", mode, 5);
    check("timer_run_tmr", tmr, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tmr_ring_buzz", buzz_out, 1);
    check("tmr_ring_src", ring_src, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press(B_INC);
    check("tmr_ack_buzz", buzz_out, 0);
    check("tmr_ack_mode", mode, 0);

    // Simultaneous alarm/timer, then alarm level held through auto-stop.
    repeat (3) press(B_MODE);
    repeat (6) press(B_NEXT);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both_ring_src", ring_src, 2);
    repeat (BUZZ_MAX - 1) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ring_last_tick", buzz_out, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ring_autostop", buzz_out, 0);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("no_rering_buzz", buzz_out, 0);
    check("no_rering_src", ring_src, 0);
    check("still_timer_run", mode, 5);
    press(B_MODE);
    check("timer_run_exit", mode, 0);

    // Alarm ring in CLOCK: acknowledging mode press is consumed.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("alm_ring_src", ring_src, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press(B_MODE);
    check("alm_ack_buzz", buzz_out, 0);
    check("alm_ack_consumed", mode, 0);

    // mode and inc together: mode wins, inc dropped.
    press(B_MODE);
    press(B_INC);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("prio_mode", mode, 2);
    check("prio_loadin", loadin, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) press(B_INC);
    check("h1_wrap", loadin, 0);
    repeat (3) press(B_NEXT);
    check("alm_last_field", select, 2);
    press(B_NEXT);
    check("alm_commit", mode, 0);

    // Reset mid-edit and mid-ring.
    press(B_MODE);
    press(B_INC);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_loadin", loadin, 1);
    check("pre_rst_buzz", buzz_out, 1);
    swrst = 1'b1;
    #1;
    check("rst_mode", mode, 0);
    check("rst_loadin", loadin, 0);
    check("rst_buzz", buzz_out, 0);
    check("rst_load", load, 0);
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; alm_hit = 1'b0; tmr_zero = 1'b0;
    repeat (2) @(posedge clk_out);
    #1 swrst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_mode", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
